wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- addr_width, 32, Wishbone address width.
- data_width, 32, Wishbone data width.
- strobe_width, data_width/8, byte-select width.
- starve_limit, 4, maximum consecutive data grants while instruction is pending; range 1..15.
- timeout_cycles, 64, cycles of unacknowledged stb before err; range 2..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_wb_cyc, d_wb_stb, d_wb_we  input  1  data-master controls.
- d_wb_adr  input  addr_width  data-master address.
- d_wb_datwr  input  data_width  data-master write data.
- d_wb_sel  input  strobe_width  data-master byte select.
- d_wb_ack, d_wb_err  output  1  data-master completion and error.
- i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_datwr, i_wb_sel  input  as d_*  instruction-master request signals.
- i_wb_ack, i_wb_err  output  1  instruction-master completion and error.
- d_wb_datrd, i_wb_datrd  output  data_width  read data to each master.
- wb_cyc, wb_stb, wb_we  output  1  shared-slave controls.
- wb_adr  output  addr_width  shared-slave address.
- wb_datwr  output  data_width  shared-slave write data.
- wb_sel  output  strobe_width  shared-slave byte select.
- wb_datrd  input  data_width  shared-slave read data.
- wb_ack  input  1  shared-slave acknowledge.

Function
REQ-003 Arbitration SHALL use a registered FSM with states IDLE, D_GNT and I_GNT.
REQ-004 Arbitration decision, taken in IDLE or when the granted master's cyc is low:
- d_wb_cyc && (!i_wb_cyc || starve_cnt < starve_limit) -> D_GNT.
- else i_wb_cyc -> I_GNT.
- else -> IDLE.
REQ-005 Grant SHALL take effect the cycle after the request is sampled; request-to-wb_cyc latency is exactly 1 cycle.
REQ-006 In D_GNT, wb_* outputs SHALL combinationally equal the d_* inputs. In I_GNT they SHALL equal the i_* inputs. In IDLE they SHALL all be 0.
REQ-007 A grant SHALL be held while the granted master keeps cyc high, including across multiple stb/ack beats; no preemption.
REQ-008 Handover on cyc drop:
- Granted master drops cyc -> decision of REQ-004 applies that cycle.
- Direct D_GNT<->I_GNT transition is allowed.
- wb_cyc is low for at least the drop cycle.
REQ-009 d_wb_ack SHALL be wb_ack && state==D_GNT. i_wb_ack SHALL be wb_ack && state==I_GNT. A non-granted master SHALL never see ack or err.
REQ-010 d_wb_datrd and i_wb_datrd SHALL both equal wb_datrd unconditionally.
REQ-011 starve_cnt is a 4-bit counter:
- +1 on each entry to D_GNT while i_wb_cyc is high, saturating at starve_limit.
- Cleared on entry to I_GNT.
- Unchanged otherwise.
REQ-012 If the granted master drops cyc before ack, the grant SHALL be released per REQ-008, and the slave SHALL see wb_cyc=0 that cycle.
REQ-013 Simultaneous ack and cyc drop on the same cycle SHALL deliver the ack and release the grant.

Reset
REQ-014 reset low SHALL asynchronously force:
- state=IDLE, starve_cnt=0, timeout counter=0.
- wb_cyc, wb_stb, wb_we, wb_adr, wb_datwr, wb_sel all 0.
- d/i_wb_ack and d/i_wb_err all 0.
REQ-015 Reset asserted mid-transaction SHALL abort it with no ack or err to either master. The first grant SHALL occur no earlier than the second rising edge after reset deassertion.

Configuration
REQ-016 Macro WB_ARB_TIMEOUT_EN, when defined, SHALL compile in the bus watchdog:
- An 8-bit counter increments while wb_stb && !wb_ack, and clears otherwise.
- On reaching timeout_cycles, it pulses the granted master's err for 1 cycle and forces wb_cyc/wb_stb to 0 in that cycle.
- The grant is then held with wb_stb masked until the master drops cyc; the counter clears.
REQ-017 Without WB_ARB_TIMEOUT_EN:
- d_wb_err and i_wb_err SHALL be constant 0.
- No watchdog logic SHALL exist.
- A stalled slave holds the grant indefinitely.

Verification
REQ-018 Bench SHALL cover, with starve_limit=2 and timeout_cycles=8:
- Only i_wb_cyc=1, adr=0x100, single read -> wb_cyc=1 next cycle, wb_adr=0x100; ack with wb_datrd=0xDEADBEEF -> i_wb_ack=1, i_wb_datrd=0xDEADBEEF, d_wb_ack=0.
- Both request continuously, 1-beat cycles -> grant order D, D, I, D, D, I.
- Data write adr=0x20, datwr=0x55AA, sel=0b0011 while i_wb_cyc held -> slave sees exactly the d_* values; i_wb_ack stays 0 until I_GNT.
- Reset pulsed low mid D_GNT before ack -> all outputs 0 immediately; no ack to either master after release.
- WB_ARB_TIMEOUT_EN defined, slave never acks -> d_wb_err=1 on the 8th stalled cycle, wb_stb=0 until d_wb_cyc drops, then pending I granted.
- WB_ARB_TIMEOUT_EN undefined, same stall -> err stays 0, grant held for 100+ cycles.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//   Two-master Wishbone arbiter. A data master (d_*) and an instruction
//   master (i_*) share one slave (wb_*). The data master normally wins.
//   The instruction master wins once the data master has been granted
//   starve_limit times in a row while the instruction master was waiting.
//   A grant is held for as long as the granted master keeps cyc high.
//
//   Optional build macro: WB_ARB_TIMEOUT_EN adds a bus watchdog. After
//   timeout_cycles consecutive stalled strobes, the watchdog pulses err to
//   the granted master and masks stb until that master drops cyc. Without
//   the macro, d_wb_err/i_wb_err are tied low and a stalled slave holds
//   the grant indefinitely.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   d_wb_*  (in)          data-master request: cyc, stb, we, adr, datwr, sel
//   d_wb_ack/err/datrd    data-master completion, error, read data
//   i_wb_*  (in)          instruction-master request, same set as d_wb_*
//   i_wb_ack/err/datrd    instruction-master completion, error, read data
//   wb_cyc..wb_sel (out)  request to the shared slave
//   wb_datrd, wb_ack (in) shared-slave read data and acknowledge
//
// Handshake: stb is "valid" and ack is "ready". A beat completes on the
// cycle where stb and ack are both high. The master holds stb and its
// payload stable until that cycle. cyc frames the whole ownership period.
module wb_master_arbiter #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int strobe_width   = data_width / 8,
    parameter int starve_limit   = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    d_wb_cyc,
    input  logic                    d_wb_stb,
    input  logic                    d_wb_we,
    input  logic [addr_width-1:0]   d_wb_adr,
    input  logic [data_width-1:0]   d_wb_datwr,
    input  logic [strobe_width-1:0] d_wb_sel,
    output logic                    d_wb_ack,
    output logic                    d_wb_err,
    output logic [data_width-1:0]   d_wb_datrd,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [addr_width-1:0]   i_wb_adr,
    input  logic [data_width-1:0]   i_wb_datwr,
    input  logic [strobe_width-1:0] i_wb_sel,
    output logic                    i_wb_ack,
    output logic                    i_wb_err,
    output logic [data_width-1:0]   i_wb_datrd,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_datwr,
    output logic [strobe_width-1:0] wb_sel,
    input  logic [data_width-1:0]   wb_datrd,
    input  logic                    wb_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_GNT = 2'd1,
        I_GNT = 2'd2
    } arb_state_t;

    // All arbitration state lives in one struct. Checkers can bind to it.
    // "armed" stays low for the first edge after reset is released. This
    // pushes the earliest possible grant to the second edge.
    typedef struct packed {
        arb_state_t state;
        logic [3:0] starve_cnt;
        logic       armed;
    } arb_regs_t;

    localparam logic [3:0] STARVE_LIM = 4'(starve_limit);

    arb_regs_t regs_q;
    arb_regs_t regs_d;
    logic      release_ok;
    logic      tmo_hit;   // watchdog fires this cycle
    logic      stb_mask;  // watchdog has fired; stb stays blocked for this grant

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q <= '{state: IDLE, starve_cnt: 4'd0, armed: 1'b0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // ---------------- next-state logic ----------------
    // The grant is re-decided only from IDLE, or on the cycle the granted
    // master lets go of cyc. There is no preemption while cyc is held.
    always_comb begin
        regs_d       = regs_q;
        regs_d.armed = 1'b1;
        release_ok   = (regs_q.state == IDLE) ||
                       (regs_q.state == D_GNT && !d_wb_cyc) ||
                       (regs_q.state == I_GNT && !i_wb_cyc);
        if (regs_q.armed && release_ok) begin
            if (d_wb_cyc && (!i_wb_cyc || regs_q.starve_cnt < STARVE_LIM)) begin
                regs_d.state = D_GNT;
            end else if (i_wb_cyc) begin
                regs_d.state = I_GNT;
            end else begin
                regs_d.state = IDLE;
            end
        end
        // Starvation accounting happens only on entry into a grant.
        if (regs_d.state == D_GNT && regs_q.state != D_GNT) begin
            if (i_wb_cyc && regs_q.starve_cnt < STARVE_LIM) begin
                regs_d.starve_cnt = regs_q.starve_cnt + 4'd1;
            end
        end else if (regs_d.state == I_GNT && regs_q.state != I_GNT) begin
            regs_d.starve_cnt = 4'd0;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_adr   = '0;
        wb_datwr = '0;
        wb_sel   = '0;
        d_wb_ack = 1'b0;
        i_wb_ack = 1'b0;
        case (regs_q.state)
            D_GNT: begin
                wb_cyc   = d_wb_cyc;
                wb_stb   = d_wb_stb && !stb_mask;
                wb_we    = d_wb_we;
                wb_adr   = d_wb_adr;
                wb_datwr = d_wb_datwr;
                wb_sel   = d_wb_sel;
                d_wb_ack = wb_ack;
            end
            I_GNT: begin
                wb_cyc   = i_wb_cyc;
                wb_stb   = i_wb_stb && !stb_mask;
                wb_we    = i_wb_we;
                wb_adr   = i_wb_adr;
                wb_datwr = i_wb_datwr;
                wb_sel   = i_wb_sel;
                i_wb_ack = wb_ack;
            end
            default: ;
        endcase
        // On the watchdog cycle the slave sees the cycle end, but the
        // grant itself is kept.
        if (tmo_hit) begin
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
        end
    end

    assign d_wb_datrd = wb_datrd;
    assign i_wb_datrd = wb_datrd;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(timeout_cycles - 1);

    logic [7:0] tmo_cnt;
    logic       mask_q;
    logic       sel_cyc;
    logic       sel_stb;

    assign sel_cyc = (regs_q.state == D_GNT) ? d_wb_cyc :
                     (regs_q.state == I_GNT) ? i_wb_cyc : 1'b0;
    assign sel_stb = (regs_q.state == D_GNT) ? d_wb_stb :
                     (regs_q.state == I_GNT) ? i_wb_stb : 1'b0;

    // tmo_cnt counts the stalled cycles already completed. The cycle that
    // would be stalled cycle number timeout_cycles raises err instead.
    assign tmo_hit  = sel_stb && !mask_q && !wb_ack && (tmo_cnt == TMO_LAST);
    assign stb_mask = mask_q;
    assign d_wb_err = tmo_hit && (regs_q.state == D_GNT);
    assign i_wb_err = tmo_hit && (regs_q.state == I_GNT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= 8'd0;
            mask_q  <= 1'b0;
        end else begin
            tmo_cnt <= (wb_stb && !wb_ack) ? tmo_cnt + 8'd1 : 8'd0;
            if (!sel_cyc) begin
                mask_q <= 1'b0;
            end else if (tmo_hit) begin
                mask_q <= 1'b1;
            end
        end
    end
`else
    logic [7:0] unused_tmo;

    assign unused_tmo = 8'(timeout_cycles);
    assign tmo_hit    = 1'b0;
    assign stb_mask   = 1'b0;
    assign d_wb_err   = 1'b0;
    assign i_wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Testbench for wb_master_arbiter with starve_limit=2 and timeout_cycles=8.
// The reference model decides each grant directly from the arbitration
// rules. It keeps a plain integer starvation count, and the expected
// grants are queued in exp_q.
module tb_wb_master_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = 4;
    localparam int STARVE = 2;
    localparam int TMO    = 8;
    localparam int NONE   = 0;
    localparam int DM     = 1;
    localparam int IM     = 2;
    localparam int BUSW   = 3 + AW + DW + SW;

    logic          clock = 1'b0;
    logic          reset;
    logic          d_wb_cyc, d_wb_stb, d_wb_we;
    logic [AW-1:0] d_wb_adr;
    logic [DW-1:0] d_wb_datwr;
    logic [SW-1:0] d_wb_sel;
    logic          d_wb_ack, d_wb_err;
    logic [DW-1:0] d_wb_datrd;
    logic          i_wb_cyc, i_wb_stb, i_wb_we;
    logic [AW-1:0] i_wb_adr;
    logic [DW-1:0] i_wb_datwr;
    logic [SW-1:0] i_wb_sel;
    logic          i_wb_ack, i_wb_err;
    logic [DW-1:0] i_wb_datrd;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_datwr;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_datrd;
    logic          wb_ack;

    logic [BUSW-1:0]   bus_act;
    logic [BUSW+3:0]   outs_act;
    logic [1:0]        exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int m_starve = 0;

    assign bus_act  = {wb_cyc, wb_stb, wb_we, wb_adr, wb_datwr, wb_sel};
    assign outs_act = {bus_act, d_wb_ack, i_wb_ack, d_wb_err, i_wb_err};

    wb_master_arbiter #(
        .addr_width    (AW),
        .data_width    (DW),
        .strobe_width  (SW),
        .starve_limit  (STARVE),
        .timeout_cycles(TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d_wb_cyc  (d_wb_cyc),
        .d_wb_stb  (d_wb_stb),
        .d_wb_we   (d_wb_we),
        .d_wb_adr  (d_wb_adr),
        .d_wb_datwr(d_wb_datwr),
        .d_wb_sel  (d_wb_sel),
        .d_wb_ack  (d_wb_ack),
        .d_wb_err  (d_wb_err),
        .d_wb_datrd(d_wb_datrd),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_adr  (i_wb_adr),
        .i_wb_datwr(i_wb_datwr),
        .i_wb_sel  (i_wb_sel),
        .i_wb_ack  (i_wb_ack),
        .i_wb_err  (i_wb_err),
        .i_wb_datrd(i_wb_datrd),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_datwr  (wb_datwr),
        .wb_sel    (wb_sel),
        .wb_datrd  (wb_datrd),
        .wb_ack    (wb_ack)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        d_wb_cyc = 1'b0; d_wb_stb = 1'b0; d_wb_we = 1'b0;
        d_wb_adr = '0; d_wb_datwr = '0; d_wb_sel = '0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_adr = '0; i_wb_datwr = '0; i_wb_sel = '0;
        wb_ack = 1'b0; wb_datrd = '0;
    endtask

    // ---------------- reference model ----------------
    // Decides who wins when the bus is free, and tracks how many times in
    // a row the data master has won while the instruction master waited.
    task automatic model_decide(input logic d, input logic i, output int win);
        if (d && (!i || m_starve < STARVE)) win = DM;
        else if (i) win = IM;
        else win = NONE;
        if (win == DM && i && m_starve < STARVE) m_starve = m_starve + 1;
        if (win == IM) m_starve = 0;
    endtask

    // The slave must see exactly the winner's request, or nothing at all.
    function automatic logic [BUSW-1:0] model_bus(input int who);
        if (who == DM) return {d_wb_cyc, d_wb_stb, d_wb_we, d_wb_adr, d_wb_datwr, d_wb_sel};
        if (who == IM) return {i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_datwr, i_wb_sel};
        return '0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int win;
        idle_inputs();
        reset = 1'b0;
        d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_adr = 32'h44;
        repeat (2) tick();
        settle();
        checks++;
        if (outs_act !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs_act);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        tick(); settle();
        checks++;
        if (wb_cyc !== 1'b0) begin
            errors++; $display("FAIL reset_first_edge_nogrant: got wb_cyc=%b expected 0", wb_cyc);
        end
        model_decide(1'b1, 1'b0, win);
        tick(); settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL reset_second_edge_grant: got %h expected %h", bus_act, model_bus(win));
        end
        d_wb_cyc = 1'b0; d_wb_stb = 1'b0; settle();
        checks++;
        if (wb_cyc !== 1'b0) begin
            errors++; $display("FAIL drop_cycle_cyc_low: got %b expected 0", wb_cyc);
        end
        tick();
    endtask

    task automatic test_single_read();
        int win;
        tick();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_adr = 32'h100; i_wb_datwr = '0; i_wb_sel = 4'hF;
        settle();
        checks++;
        if (wb_cyc !== 1'b0) begin
            errors++; $display("FAIL single_read_same_cycle: got wb_cyc=%b expected 0", wb_cyc);
        end
        model_decide(1'b0, 1'b1, win);
        tick(); settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL single_read_bus: got %h expected %h", bus_act, model_bus(win));
        end
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h100}) begin
            errors++; $display("FAIL single_read_adr: got cyc=%b adr=%h expected 1/100", wb_cyc, wb_adr);
        end
        wb_ack = 1'b1; wb_datrd = 32'hDEADBEEF; settle();
        checks++;
        if ({i_wb_ack, d_wb_ack} !== 2'b10) begin
            errors++; $display("FAIL single_read_ack_route: got i=%b d=%b expected i=1 d=0", i_wb_ack, d_wb_ack);
        end
        checks++;
        if (i_wb_datrd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_read_datrd: got %h expected deadbeef", i_wb_datrd);
        end
        tick();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; wb_ack = 1'b0; settle();
        checks++;
        if (wb_cyc !== 1'b0) begin
            errors++; $display("FAIL single_read_release: got wb_cyc=%b expected 0", wb_cyc);
        end
        tick();
    endtask

    task automatic test_data_write();
        int win;
        tick();
        d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = 1'b1;
        d_wb_adr = 32'h20; d_wb_datwr = 32'h55AA; d_wb_sel = 4'b0011;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_adr = 32'h300; i_wb_datwr = 32'h1; i_wb_sel = 4'hF;
        model_decide(1'b1, 1'b1, win);
        tick(); settle();
        checks++;
        if ({wb_we, wb_adr, wb_datwr, wb_sel} !== {1'b1, 32'h20, 32'h55AA, 4'b0011}) begin
            errors++; $display("FAIL write_fields: got we=%b adr=%h dat=%h sel=%b expected 1/20/55aa/0011",
                               wb_we, wb_adr, wb_datwr, wb_sel);
        end
        for (int b = 0; b < 3; b++) begin
            wb_ack = 1'b1; settle();
            checks++;
            if (bus_act !== model_bus(win)) begin
                errors++; $display("FAIL write_beat_bus: beat %0d got %h expected %h", b, bus_act, model_bus(win));
            end
            checks++;
            if ({d_wb_ack, i_wb_ack} !== 2'b10) begin
                errors++; $display("FAIL write_beat_ack: beat %0d got d=%b i=%b expected d=1 i=0", b, d_wb_ack, i_wb_ack);
            end
            tick();
            d_wb_datwr = $urandom;
        end
        // ack and cyc drop on the same cycle
        wb_ack = 1'b1; d_wb_cyc = 1'b0; d_wb_stb = 1'b0; settle();
        checks++;
        if ({d_wb_ack, i_wb_ack, wb_cyc} !== 3'b100) begin
            errors++; $display("FAIL write_ack_with_drop: got d=%b i=%b cyc=%b expected 1/0/0", d_wb_ack, i_wb_ack, wb_cyc);
        end
        model_decide(1'b0, 1'b1, win);
        tick(); wb_ack = 1'b0; settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL handover_to_i: got %h expected %h", bus_act, model_bus(win));
        end
        wb_ack = 1'b1; settle();
        checks++;
        if ({d_wb_ack, i_wb_ack} !== 2'b01) begin
            errors++; $display("FAIL handover_i_ack: got d=%b i=%b expected d=0 i=1", d_wb_ack, i_wb_ack);
        end
        tick();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; wb_ack = 1'b0;
        tick();
    endtask

    task automatic test_starve_order();
        int        win;
        int        exp_who;
        logic [1:0] order [6];
        order = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
        for (int r = 0; r < 6; r++) exp_q.push_back(order[r]);
        for (int r = 0; r < 6; r++) begin
            d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = 1'b0; d_wb_adr = 32'hD000 + r;
            i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h1000 + r;
            model_decide(1'b1, 1'b1, win);
            tick(); settle();
            exp_who = int'(exp_q.pop_front());
            checks++;
            if (bus_act !== model_bus(exp_who)) begin
                errors++; $display("FAIL starve_order_grant: round %0d got adr=%h expected %h",
                                   r, wb_adr, (exp_who == DM) ? d_wb_adr : i_wb_adr);
            end
            wb_ack = 1'b1;
            d_wb_cyc = 1'b0; d_wb_stb = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
            settle();
            checks++;
            if ({d_wb_ack, i_wb_ack} !== ((exp_who == DM) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL starve_order_ack: round %0d got d=%b i=%b", r, d_wb_ack, i_wb_ack);
            end
            tick();
            wb_ack = 1'b0;
        end
    endtask

    task automatic test_random();
        int            win;
        int            win2;
        int            exp_who;
        logic          dreq, ireq, handover;
        logic [DW-1:0] rdata;
        logic [1:0]    exp_acks;
        for (int r = 0; r < 40; r++) begin
            dreq = 1'($urandom_range(0, 1));
            ireq = 1'($urandom_range(0, 1));
            d_wb_cyc = dreq; d_wb_stb = dreq; d_wb_we = 1'($urandom_range(0, 1));
            d_wb_adr = $urandom; d_wb_datwr = $urandom; d_wb_sel = 4'($urandom_range(0, 15));
            i_wb_cyc = ireq; i_wb_stb = ireq; i_wb_we = 1'($urandom_range(0, 1));
            i_wb_adr = $urandom; i_wb_datwr = $urandom; i_wb_sel = 4'($urandom_range(0, 15));
            model_decide(dreq, ireq, win);
            exp_q.push_back(2'(win));
            tick(); settle();
            exp_who = int'(exp_q.pop_front());
            checks++;
            if (bus_act !== model_bus(exp_who)) begin
                errors++; $display("FAIL rand_grant: round %0d got %h expected %h", r, bus_act, model_bus(exp_who));
            end
            rdata = $urandom; wb_ack = 1'b1; wb_datrd = rdata; settle();
            exp_acks = (exp_who == DM) ? 2'b10 : (exp_who == IM) ? 2'b01 : 2'b00;
            checks++;
            if ({d_wb_ack, i_wb_ack, d_wb_datrd, i_wb_datrd} !== {exp_acks, rdata, rdata}) begin
                errors++; $display("FAIL rand_ack: round %0d got acks=%b%b dat=%h/%h expected %b %h",
                                   r, d_wb_ack, i_wb_ack, d_wb_datrd, i_wb_datrd, exp_acks, rdata);
            end
            handover = dreq && ireq && 1'($urandom_range(0, 1));
            tick();
            wb_ack = 1'b0;
            if (exp_who == DM) begin
                d_wb_cyc = 1'b0; d_wb_stb = 1'b0;
                if (!handover) begin i_wb_cyc = 1'b0; i_wb_stb = 1'b0; end
            end else begin
                i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
                if (!handover) begin d_wb_cyc = 1'b0; d_wb_stb = 1'b0; end
            end
            settle();
            checks++;
            if (wb_cyc !== 1'b0) begin
                errors++; $display("FAIL rand_drop_cycle: round %0d got wb_cyc=%b expected 0", r, wb_cyc);
            end
            if (handover) begin
                model_decide(d_wb_cyc, i_wb_cyc, win2);
                tick(); settle();
                checks++;
                if (bus_act !== model_bus(win2)) begin
                    errors++; $display("FAIL rand_handover: round %0d got %h expected %h", r, bus_act, model_bus(win2));
                end
                d_wb_cyc = 1'b0; d_wb_stb = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int win;
        tick();
        d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = 1'b1;
        d_wb_adr = 32'hABC; d_wb_datwr = 32'h1234; d_wb_sel = 4'hF;
        model_decide(1'b1, 1'b0, win);
        tick(); settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL reset_mid_granted: got %h expected %h", bus_act, model_bus(win));
        end
        #1 reset = 1'b0; wb_ack = 1'b1;
        #1;
        checks++;
        if (outs_act !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h expected 0", outs_act);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        m_starve = 0;
        tick(); settle();
        checks++;
        if ({d_wb_ack, i_wb_ack, wb_cyc} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_no_ack: got d=%b i=%b cyc=%b expected 0/0/0", d_wb_ack, i_wb_ack, wb_cyc);
        end
        idle_inputs();
        tick(); tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int win;
        tick();
        d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = 1'b0; d_wb_adr = 32'h40;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h80;
        wb_ack = 1'b0;
        model_decide(1'b1, 1'b1, win);
        tick(); settle();
        for (int c = 1; c < TMO; c++) begin
            checks++;
            if ({d_wb_err, i_wb_err, wb_cyc, wb_stb} !== 4'b0011) begin
                errors++; $display("FAIL tmo_pre_err: stall %0d got err=%b%b cyc=%b stb=%b expected 0011",
                                   c, d_wb_err, i_wb_err, wb_cyc, wb_stb);
            end
            tick(); settle();
        end
        checks++;
        if ({d_wb_err, i_wb_err, wb_cyc, wb_stb} !== 4'b1000) begin
            errors++; $display("FAIL tmo_err_pulse: got err=%b%b cyc=%b stb=%b expected 1000",
                               d_wb_err, i_wb_err, wb_cyc, wb_stb);
        end
        for (int c = 0; c < 4; c++) begin
            tick(); settle();
            checks++;
            if ({d_wb_err, i_wb_err, wb_cyc, wb_stb, wb_adr} !== {4'b0010, 32'h40}) begin
                errors++; $display("FAIL tmo_masked: cycle %0d got err=%b%b cyc=%b stb=%b adr=%h expected 0010/40",
                                   c, d_wb_err, i_wb_err, wb_cyc, wb_stb, wb_adr);
            end
        end
        d_wb_cyc = 1'b0; d_wb_stb = 1'b0;
        model_decide(1'b0, 1'b1, win);
        tick(); settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL tmo_handover_i: got %h expected %h", bus_act, model_bus(win));
        end
        wb_ack = 1'b1; settle();
        checks++;
        if ({i_wb_ack, d_wb_ack, d_wb_err, i_wb_err} !== 4'b1000) begin
            errors++; $display("FAIL tmo_i_ack: got i=%b d=%b err=%b%b expected 1/0/00", i_wb_ack, d_wb_ack, d_wb_err, i_wb_err);
        end
        tick();
        idle_inputs();
        tick();
    endtask
`else
    task automatic test_stall_no_timeout();
        int win;
        tick();
        d_wb_cyc = 1'b1; d_wb_stb = 1'b1; d_wb_we = 1'b0; d_wb_adr = 32'h40;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h80;
        wb_ack = 1'b0;
        model_decide(1'b1, 1'b1, win);
        tick(); settle();
        for (int c = 1; c <= 120; c++) begin
            checks++;
            if ({d_wb_err, i_wb_err, wb_cyc, wb_stb, wb_adr} !== {4'b0011, 32'h40}) begin
                errors++; $display("FAIL stall_hold: cycle %0d got err=%b%b cyc=%b stb=%b adr=%h expected 0011/40",
                                   c, d_wb_err, i_wb_err, wb_cyc, wb_stb, wb_adr);
            end
            tick(); settle();
        end
        d_wb_cyc = 1'b0; d_wb_stb = 1'b0;
        model_decide(1'b0, 1'b1, win);
        tick(); settle();
        checks++;
        if (bus_act !== model_bus(win)) begin
            errors++; $display("FAIL stall_handover_i: got %h expected %h", bus_act, model_bus(win));
        end
        tick();
        idle_inputs();
        tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_data_write();
        test_starve_order();
        test_random();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_stall_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
